// File: rtl/gpio_probe_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_probe_pkg
// Brief    : Command codes, GPIO word field positions and FSM state type
//            shared by the GPIO probe multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_probe_pkg;

  // Host command codes (GPIO_IN[31:28])
  localparam logic [3:0] CMD_NOP      = 4'd0;
  localparam logic [3:0] CMD_SNAP     = 4'd1;
  localparam logic [3:0] CMD_READ     = 4'd2;
  localparam logic [3:0] CMD_LIVE     = 4'd3;
  localparam logic [3:0] CMD_SET_A    = 4'd4;
  localparam logic [3:0] CMD_SET_B    = 4'd5;
  localparam logic [3:0] CMD_OVR      = 4'd6;
  localparam logic [3:0] CMD_NEXT     = 4'd7;
  localparam logic [3:0] CMD_UNFREEZE = 4'd8;

  // Field positions shared by the command and response words
  localparam int CMD_MSB     = 31;
  localparam int CMD_LSB     = 28;
  localparam int TOG_BIT     = 27;
  localparam int ARG_MSB     = 26;
  localparam int ACK_BIT     = 27;
  localparam int BAD_CMD_BIT = 26;
  localparam int BAD_IDX_BIT = 25;
  localparam int LIVE_BIT    = 24;
  localparam int DATA_MSB    = 23;

  // Handshake FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes 9..15 are reserved and flagged as BAD_CMD
  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    return (cmd <= CMD_UNFREEZE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_probe_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_probe_mux_if
// Brief    : Bus bundle between the host GPIO bridge / SPGD datapath (master)
//            and the probe multiplexer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_probe_mux_if #(
  parameter int DATA_WIDTH = 14,
  parameter int NUM_CH     = 16,
  parameter int GPIO_WIDTH = 32
);
  logic [GPIO_WIDTH-1:0]        gpio_in;
  logic [NUM_CH*DATA_WIDTH-1:0] probe;
  logic [GPIO_WIDTH-1:0]        gpio_out;
  logic                         dac_ovr_en;
  logic [DATA_WIDTH-1:0]        dac_ovr_a;
  logic [DATA_WIDTH-1:0]        dac_ovr_b;
  logic                         frozen;

  modport master (
    output gpio_in, probe,
    input  gpio_out, dac_ovr_en, dac_ovr_a, dac_ovr_b, frozen
  );

  modport slave (
    input  gpio_in, probe,
    output gpio_out, dac_ovr_en, dac_ovr_a, dac_ovr_b, frozen
  );
endinterface
`default_nettype wire

// File: rtl/gpio_probe_mux_sync.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync
// Brief    : Two-flop synchroniser for the host GPIO word, async reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage1;
  logic [WIDTH-1:0] r_stage2;

  // Two back-to-back flops bring the host word into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= i_d;
      r_stage2 <= r_stage1;
    end
  end

  assign o_q = r_stage2;

endmodule
`default_nettype wire

// File: rtl/gpio_probe_mux.sv
`default_nettype none
// ============================================================================
// Module   : gpio_probe_mux
// Brief    : Host-commanded probe snapshot / readback / live stream with DAC
//            override, using a toggle/acknowledge handshake on the GPIO word.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_probe_mux
  import gpio_probe_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int NUM_CH     = 16,
  parameter int GPIO_WIDTH = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  gpio_probe_mux_if.slave   bus
);

  localparam int         IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] LAST_IDX = 8'(NUM_CH - 1);

  logic [GPIO_WIDTH-1:0] w_gpio_sync;
  logic [DATA_WIDTH-1:0] w_probe [NUM_CH];
  logic [DATA_WIDTH-1:0] r_shadow [NUM_CH];

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_latch;
  logic                  w_exec;
  logic                  w_resp;

  logic [3:0]            r_cmd;
  logic                  r_tog;
  logic [ARG_MSB:0]      r_arg;

  logic [3:0]            r_echo;
  logic                  r_ack;
  logic                  r_bad_cmd;
  logic                  r_bad_idx;
  logic                  r_live;
  logic                  r_frozen;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_idx;
  logic                  r_ovr_en;
  logic [DATA_WIDTH-1:0] r_ovr_a;
  logic [DATA_WIDTH-1:0] r_ovr_b;

  logic [7:0]            w_arg_idx;
  logic                  w_idx_ok;
  logic [7:0]            w_next_idx;
  logic [DATA_WIDTH-1:0] w_live_val;

  gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.gpio_in),
    .o_q (w_gpio_sync)
  );

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign w_probe[k] = bus.probe[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: one command in flight, pending means synced TOG != ACK
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_exec      = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gpio_sync[TOG_BIT] != r_ack) begin
          w_latch     = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Index arithmetic for READ/LIVE bounds checking and NEXT wrap
  always_comb begin
    w_arg_idx  = r_arg[7:0];
    w_idx_ok   = ({1'b0, w_arg_idx} < 9'(NUM_CH));
    w_next_idx = (r_idx == LAST_IDX) ? 8'd0 : r_idx + 8'd1;
    w_live_val = w_probe[r_idx[IDX_W-1:0]];
  end

  // Capture the command word the cycle it is seen pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd <= '0;
      r_tog <= 1'b0;
      r_arg <= '0;
    end else if (w_latch) begin
      r_cmd <= w_gpio_sync[CMD_MSB:CMD_LSB];
      r_tog <= w_gpio_sync[TOG_BIT];
      r_arg <= w_gpio_sync[ARG_MSB:0];
    end
  end

  // Shadow bank: every channel captured together on SNAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
    end else if (w_exec && (r_cmd == CMD_SNAP)) begin
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= w_probe[i];
    end
  end

  // Command execution, response fields, overrides and live streaming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_echo    <= '0;
      r_ack     <= 1'b0;
      r_bad_cmd <= 1'b0;
      r_bad_idx <= 1'b0;
      r_live    <= 1'b0;
      r_frozen  <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_ovr_en  <= 1'b0;
      r_ovr_a   <= '0;
      r_ovr_b   <= '0;
    end else begin
      if (w_exec) begin
        r_echo <= r_cmd;
        if (!cmd_is_valid(r_cmd)) begin
          // Reserved code: flag it, freeze DATA by stopping any live stream
          r_bad_cmd <= 1'b1;
          r_live    <= 1'b0;
        end else begin
          r_bad_cmd <= 1'b0;
          r_bad_idx <= 1'b0;
          // NOP handshakes keep an active live stream running
          if (r_cmd != CMD_NOP) r_live <= 1'b0;
          case (r_cmd)
            CMD_NOP: begin
              if (r_live) r_data <= w_live_val;
            end
            CMD_SNAP:     r_frozen <= 1'b1;
            CMD_UNFREEZE: r_frozen <= 1'b0;
            CMD_READ: begin
              if (w_idx_ok) begin
                r_idx  <= w_arg_idx;
                r_data <= r_shadow[w_arg_idx[IDX_W-1:0]];
              end else begin
                r_bad_idx <= 1'b1;
                r_data    <= '0;
              end
            end
            CMD_LIVE: begin
              if (w_idx_ok) begin
                r_idx  <= w_arg_idx;
                r_live <= 1'b1;
                r_data <= w_probe[w_arg_idx[IDX_W-1:0]];
              end else begin
                r_bad_idx <= 1'b1;
                r_data    <= '0;
              end
            end
            CMD_NEXT: begin
              r_idx  <= w_next_idx;
              r_data <= r_shadow[w_next_idx[IDX_W-1:0]];
            end
            CMD_SET_A: r_ovr_a  <= r_arg[DATA_WIDTH-1:0];
            CMD_SET_B: r_ovr_b  <= r_arg[DATA_WIDTH-1:0];
            CMD_OVR:   r_ovr_en <= r_arg[0];
            default: ;
          endcase
        end
      end else if (r_live) begin
        r_data <= w_live_val;
      end
      // ACK trails DATA by one cycle so the host sees stable data
      if (w_resp) r_ack <= r_tog;
    end
  end

  assign bus.gpio_out   = {r_echo, r_ack, r_bad_cmd, r_bad_idx, r_live,
                           (DATA_MSB + 1)'(r_data)};
  assign bus.dac_ovr_en = r_ovr_en;
  assign bus.dac_ovr_a  = r_ovr_a;
  assign bus.dac_ovr_b  = r_ovr_b;
  assign bus.frozen     = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_gpio_probe_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_probe_mux
// Brief    : Directed scoreboard bench for gpio_probe_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_probe_mux;
  import gpio_probe_pkg::*;

  localparam int DW  = 14;
  localparam int NCH = 16;
  localparam int GW  = 32;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] side;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  gpio_probe_mux_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .GPIO_WIDTH(GW)) bus ();

  gpio_probe_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .GPIO_WIDTH(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] side_w();
    return {2'b00, bus.frozen, bus.dac_ovr_en, bus.dac_ovr_a, bus.dac_ovr_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    bus.probe[k*DW +: DW] = v;
  endtask

  // Issue one command and check edge-3 (no change) and edge-4 (new values,
  // old ACK) timing; the monitor checks the full word when ACK flips.
  task automatic send(input logic [3:0] cmd, input logic [26:0] arg,
                      input logic [23:0] data, input logic bc, input logic bi,
                      input logic lv, input logic frz, input logic en,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] before_out;
    logic [31:0] before_side;
    exp_t        e;
    @(negedge clk);
    tog         = ~tog;
    before_out  = bus.gpio_out;
    before_side = side_w();
    e.out       = {cmd, tog, bc, bi, lv, data};
    e.side      = {2'b00, frz, en, a, b};
    q.push_back(e);
    bus.gpio_in = {cmd, tog, arg};
    repeat (3) @(negedge clk);
    chk("edge3_out", bus.gpio_out, before_out);
    chk("edge3_side", side_w(), before_side);
    @(negedge clk);
    chk("edge4_out", bus.gpio_out, {cmd, ~tog, bc, bi, lv, data});
    chk("edge4_side", side_w(), e.side);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: each ACK flip pops one expected response
  initial begin
    logic prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 1'b0;
      end else if (bus.gpio_out[ACK_BIT] != prev_ack) begin
        prev_ack = bus.gpio_out[ACK_BIT];
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=%0b want no ack", prev_ack);
        end else begin
          e = q.pop_front();
          chk("ack_out", bus.gpio_out, e.out);
          chk("ack_side", side_w(), e.side);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    bus.gpio_in = '0;
    bus.probe   = '0;
    set_ch(0,  14'h0123);
    set_ch(1,  14'h1111);
    set_ch(3,  14'h2BDB);
    set_ch(5,  14'h0666);
    set_ch(15, 14'h3C3C);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out", bus.gpio_out, 32'h0);
    chk("reset_side", side_w(), 32'h0);

    // Snapshot, then disturb the live probes to prove the bank holds
    send(CMD_SNAP, 27'd0, 24'h0, 0, 0, 0, 1, 0, 14'h0, 14'h0);
    set_ch(3, 14'h0001);
    set_ch(0, 14'h0000);
    send(CMD_READ, 27'd3, 24'h002BDB, 0, 0, 0, 1, 0, 14'h0, 14'h0);

    // Live stream channel 5 with one-cycle latency
    send(CMD_LIVE, 27'd5, 24'h000666, 0, 0, 1, 1, 0, 14'h0, 14'h0);
    @(negedge clk);
    set_ch(5, 14'h0777);
    chk("live_hold", 32'(bus.gpio_out[DW-1:0]), 32'h0666);
    @(negedge clk);
    chk("live_follow", 32'(bus.gpio_out[DW-1:0]), 32'h0777);
    chk("live_flag", 32'(bus.gpio_out[LIVE_BIT]), 32'h1);
    send(CMD_READ, 27'd3, 24'h002BDB, 0, 0, 0, 1, 0, 14'h0, 14'h0);

    // DAC overrides
    send(CMD_SET_A, 27'h1DDD, 24'h002BDB, 0, 0, 0, 1, 0, 14'h1DDD, 14'h0);
    send(CMD_SET_B, 27'h3A98, 24'h002BDB, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_OVR,   27'd1,    24'h002BDB, 0, 0, 0, 1, 1, 14'h1DDD, 14'h3A98);
    send(CMD_OVR,   27'd0,    24'h002BDB, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);

    // NEXT wrap, bad index, NEXT after bad index
    send(CMD_READ, 27'd15,  24'h003C3C, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_NEXT, 27'd0,   24'h000123, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_READ, 27'hFF,  24'h000000, 0, 1, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_NEXT, 27'd0,   24'h001111, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);

    // Reserved command, then recovery and unfreeze
    send(4'hA,         27'd2, 24'h001111, 1, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_READ,     27'd3, 24'h002BDB, 0, 0, 0, 1, 0, 14'h1DDD, 14'h3A98);
    send(CMD_UNFREEZE, 27'd0, 24'h002BDB, 0, 0, 0, 0, 0, 14'h1DDD, 14'h3A98);

    // Double TOG flip while a READ is in flight: exactly one ACK
    begin
      exp_t e;
      @(negedge clk);
      tog    = ~tog;
      e.out  = {CMD_READ, tog, 1'b0, 1'b0, 1'b0, 24'h000123};
      e.side = {2'b00, 1'b0, 1'b0, 14'h1DDD, 14'h3A98};
      q.push_back(e);
      bus.gpio_in = {CMD_READ, tog, 27'd0};
      repeat (2) @(negedge clk);
      bus.gpio_in[TOG_BIT] = ~tog;
      @(negedge clk);
      bus.gpio_in[TOG_BIT] = tog;
      repeat (16) @(negedge clk);
      chk("dbl_tog_ack", 32'(bus.gpio_out[ACK_BIT]), 32'(tog));
    end

    // Reset between edge 3 and edge 4 of SET_A aborts it
    @(negedge clk);
    tog = ~tog;
    bus.gpio_in = {CMD_SET_A, tog, 27'h0ABC};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.gpio_in = '0;
    tog = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_out", bus.gpio_out, 32'h0);
    chk("abort_side", side_w(), 32'h0);

    // FSM back in IDLE with cleared shadow bank
    send(CMD_READ, 27'd3, 24'h000000, 0, 0, 0, 0, 0, 14'h0, 14'h0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
